// File: rtl/qpsk_tx_ctrl_if.sv
// qpsk_tx_ctrl_if: byte stream handshake into the QPSK TX sequencer.
// master = byte source (framer/FIFO), slave = qpsk_tx_ctrl.
//   byte_data  [7:0]  payload byte
//   byte_valid        byte_data is valid
//   byte_ready        sink accepts byte (transfer = valid & ready)
interface qpsk_tx_ctrl_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/qpsk_tx_ctrl.sv
// qpsk_tx_ctrl: preamble + payload dibit sequencer feeding the QPSK mapper.
// Ports: clk, rst_n (async, active-low), start, frame_len[LEN_W-1:0],
//   byte_if (slave: byte_data/byte_valid in, byte_ready out, comb),
//   sm_din[1:0], sym_valid, sym_strobe, busy, done, underrun (registered).
module qpsk_tx_ctrl #(
    parameter int SPS     = 4,
    parameter int PRE_LEN = 8,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    qpsk_tx_ctrl_if.slave    byte_if,
    output logic [1:0]       sm_din,
    output logic             sym_valid,
    output logic             sym_strobe,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int SYM_W = (PRE_LEN > 4) ? $clog2(PRE_LEN) : 2;

    localparam logic [CNT_W-1:0] SPS_LAST = CNT_W'(SPS - 1);
    localparam logic [SYM_W-1:0] PRE_LAST = SYM_W'(PRE_LEN - 1);
    localparam logic [SYM_W-1:0] DIB_LAST = SYM_W'(3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_PAY,
        S_STALL
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] sps_cnt, sps_n;
    logic [SYM_W-1:0] sym_cnt, sym_n;
    logic [LEN_W-1:0] rem, rem_n;
    logic [7:0]       shreg, sh_n;

    logic [1:0] din_d;
    logic       sv_d;
    logic       stb_d;
    logic       busy_d;
    logic       done_d;
    logic       und_d;

    logic sym_end;
    logic boundary;
    logic more;
    logic rdy;
    logic xfer;

    // Boundary: last clock of the last preamble symbol or of dibit [1:0].
    assign sym_end  = (sps_cnt == SPS_LAST);
    assign more     = (rem != '0);
    assign boundary = sym_end &&
                      (((state == S_PRE) && (sym_cnt == PRE_LAST)) ||
                       ((state == S_PAY) && (sym_cnt == DIB_LAST)));

    // rem only counts bytes not yet accepted, so STALL always has one due.
    assign rdy  = (boundary && more) || (state == S_STALL);
    assign xfer = rdy && byte_if.byte_valid;

    assign byte_if.byte_ready = rdy;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sps_cnt    <= '0;
            sym_cnt    <= '0;
            rem        <= '0;
            shreg      <= '0;
            sm_din     <= 2'b00;
            sym_valid  <= 1'b0;
            sym_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            sps_cnt    <= sps_n;
            sym_cnt    <= sym_n;
            rem        <= rem_n;
            shreg      <= sh_n;
            sm_din     <= din_d;
            sym_valid  <= sv_d;
            sym_strobe <= stb_d;
            busy       <= busy_d;
            done       <= done_d;
            underrun   <= und_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_n = state;
        sps_n   = sps_cnt;
        sym_n   = sym_cnt;
        rem_n   = rem;
        sh_n    = shreg;

        unique case (state)
            S_IDLE: begin
                if (start && (frame_len != '0)) begin
                    state_n = S_PRE;
                    sps_n   = '0;
                    sym_n   = '0;
                    rem_n   = frame_len;
                end
            end

            S_PRE, S_PAY: begin
                if (xfer) begin
                    state_n = S_PAY;
                    sps_n   = '0;
                    sym_n   = '0;
                    sh_n    = byte_if.byte_data;
                    rem_n   = rem - LEN_W'(1);
                end else if (boundary) begin
                    state_n = more ? S_STALL : S_IDLE;
                    sps_n   = '0;
                    sym_n   = '0;
                end else if (sym_end) begin
                    sps_n = '0;
                    sym_n = sym_cnt + SYM_W'(1);
                    if (state == S_PAY) begin
                        sh_n = {shreg[5:0], 2'b00};
                    end
                end else begin
                    sps_n = sps_cnt + CNT_W'(1);
                end
            end

            S_STALL: begin
                if (xfer) begin
                    state_n = S_PAY;
                    sps_n   = '0;
                    sym_n   = '0;
                    sh_n    = byte_if.byte_data;
                    rem_n   = rem - LEN_W'(1);
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so registered outputs line up
    // with the state they describe.
    always_comb begin
        din_d  = 2'b00;
        sv_d   = 1'b0;
        busy_d = (state_n != S_IDLE);
        done_d = (state != S_IDLE) && (state_n == S_IDLE);
        und_d  = (state != S_STALL) && (state_n == S_STALL);

        unique case (state_n)
            S_PRE: begin
                sv_d  = 1'b1;
                din_d = {2{sym_n[0]}};
            end
            S_PAY: begin
                sv_d  = 1'b1;
                din_d = sh_n[7:6];
            end
            default: begin
                sv_d  = 1'b0;
                din_d = 2'b00;
            end
        endcase

        stb_d = sv_d && (sps_n == '0);
    end

endmodule

// File: tb/tb_qpsk_tx_ctrl.sv
// tb_qpsk_tx_ctrl: table-driven bench for qpsk_tx_ctrl.
// Two instances: SPS=4/PRE_LEN=8 (a) and SPS=1/PRE_LEN=2 (b).
module tb_qpsk_tx_ctrl;

    typedef struct {
        logic       start;
        logic [7:0] flen;
        logic       vin;
        logic [7:0] data;
        logic [1:0] e_din;
        logic       e_sv;
        logic       e_stb;
        logic       e_busy;
        logic       e_done;
        logic       e_und;
        logic       e_rdy;
    } vec_t;

    logic clk;
    logic rst_n;

    logic       start_a, start_b;
    logic [7:0] flen_a, flen_b;

    logic [1:0] a_din, b_din;
    logic       a_sv, a_stb, a_busy, a_done, a_und;
    logic       b_sv, b_stb, b_busy, b_done, b_und;

    qpsk_tx_ctrl_if bi_a ();
    qpsk_tx_ctrl_if bi_b ();

    int   nvec = 0;
    int   nerr = 0;
    vec_t q[$];

    qpsk_tx_ctrl #(.SPS(4), .PRE_LEN(8), .LEN_W(8)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_a),
        .frame_len  (flen_a),
        .byte_if    (bi_a.slave),
        .sm_din     (a_din),
        .sym_valid  (a_sv),
        .sym_strobe (a_stb),
        .busy       (a_busy),
        .done       (a_done),
        .underrun   (a_und)
    );

    qpsk_tx_ctrl #(.SPS(1), .PRE_LEN(2), .LEN_W(8)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_b),
        .frame_len  (flen_b),
        .byte_if    (bi_b.slave),
        .sm_din     (b_din),
        .sym_valid  (b_sv),
        .sym_strobe (b_stb),
        .busy       (b_busy),
        .done       (b_done),
        .underrun   (b_und)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [7:0] act,
                         input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_idle(input string tag, input int which);
        logic [1:0] dn;
        logic       sv, stb, bz, dd, un, rd;
        if (which == 0) begin
            dn = a_din; sv = a_sv; stb = a_stb; bz = a_busy;
            dd = a_done; un = a_und; rd = bi_a.byte_ready;
        end else begin
            dn = b_din; sv = b_sv; stb = b_stb; bz = b_busy;
            dd = b_done; un = b_und; rd = bi_b.byte_ready;
        end
        check({tag, ".din"}, 8'(dn), 8'h0);
        check({tag, ".sv"}, 8'(sv), 8'h0);
        check({tag, ".stb"}, 8'(stb), 8'h0);
        check({tag, ".busy"}, 8'(bz), 8'h0);
        check({tag, ".done"}, 8'(dd), 8'h0);
        check({tag, ".und"}, 8'(un), 8'h0);
        check({tag, ".rdy"}, 8'(rd), 8'h0);
    endtask

    // Expected frame: start cycle, preamble, optional stall before byte
    // stall_idx, payload dibits, done cycle, one trailing idle cycle.
    task automatic build(input int sps, input int pre, input int nb,
                         input logic [7:0] b0, input logic [7:0] b1,
                         input int stall_idx, input int stall_len,
                         input bit mid_start);
        vec_t       v;
        logic [7:0] b[2];
        int         nx;
        b[0] = b0;
        b[1] = b1;
        q.delete();
        v = '{default: 0};
        v.start = 1'b1; v.flen = 8'(nb);
        v.vin = (stall_idx != 0); v.data = b[0];
        q.push_back(v);
        for (int s = 0; s < pre; s++) begin
            for (int c = 0; c < sps; c++) begin
                v = '{default: 0};
                v.flen = 8'(nb); v.vin = (stall_idx != 0); v.data = b[0];
                v.e_sv = 1'b1; v.e_busy = 1'b1;
                v.e_din = (s % 2 == 1) ? 2'b11 : 2'b00;
                v.e_stb = (c == 0);
                v.e_rdy = (s == pre - 1) && (c == sps - 1);
                q.push_back(v);
            end
        end
        for (int k = 0; k < nb; k++) begin
            if (k == stall_idx) begin
                q[q.size() - 1].vin = 1'b0;
                for (int j = 0; j < stall_len; j++) begin
                    v = '{default: 0};
                    v.flen = 8'(nb); v.vin = (j == stall_len - 1);
                    v.data = b[k];
                    v.e_busy = 1'b1; v.e_rdy = 1'b1; v.e_und = (j == 0);
                    q.push_back(v);
                end
            end
            nx = (k + 1 < nb) ? k + 1 : k;
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < sps; c++) begin
                    v = '{default: 0};
                    v.flen = 8'(nb); v.data = b[nx];
                    v.vin = (k + 1 < nb) ? (k + 1 != stall_idx) : 1'b1;
                    v.e_sv = 1'b1; v.e_busy = 1'b1;
                    v.e_din = 2'(b[k] >> (6 - 2 * d));
                    v.e_stb = (c == 0);
                    v.e_rdy = (d == 3) && (c == sps - 1) && (k + 1 < nb);
                    q.push_back(v);
                end
            end
        end
        v = '{default: 0};
        v.flen = 8'(nb); v.vin = 1'b1; v.data = b[nb - 1];
        v.e_done = 1'b1;
        q.push_back(v);
        v.e_done = 1'b0;
        q.push_back(v);
        if (mid_start) begin
            q[5].start = 1'b1;
            q[5].flen = 8'd3;
            q[q.size() - 3].start = 1'b1;
        end
    endtask

    task automatic apply(input string tag, input int which, input int n);
        vec_t       v;
        logic [1:0] dn;
        logic       sv, stb, bz, dd, un, rd;
        string      nm;
        for (int i = 0; i < n; i++) begin
            v = q[i];
            if (which == 0) begin
                start_a = v.start; flen_a = v.flen;
                bi_a.byte_valid = v.vin; bi_a.byte_data = v.data;
                dn = a_din; sv = a_sv; stb = a_stb; bz = a_busy;
                dd = a_done; un = a_und; rd = bi_a.byte_ready;
            end else begin
                start_b = v.start; flen_b = v.flen;
                bi_b.byte_valid = v.vin; bi_b.byte_data = v.data;
                dn = b_din; sv = b_sv; stb = b_stb; bz = b_busy;
                dd = b_done; un = b_und; rd = bi_b.byte_ready;
            end
            nm = $sformatf("%s[%0d]", tag, i);
            check({nm, ".din"}, 8'(dn), 8'(v.e_din));
            check({nm, ".sv"}, 8'(sv), 8'(v.e_sv));
            check({nm, ".stb"}, 8'(stb), 8'(v.e_stb));
            check({nm, ".busy"}, 8'(bz), 8'(v.e_busy));
            check({nm, ".done"}, 8'(dd), 8'(v.e_done));
            check({nm, ".und"}, 8'(un), 8'(v.e_und));
            check({nm, ".rdy"}, 8'(rd), 8'(v.e_rdy));
            @(posedge clk);
            #1;
        end
        start_a = 1'b0; start_b = 1'b0;
        bi_a.byte_valid = 1'b0; bi_b.byte_valid = 1'b0;
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        flen_a = 8'd0; flen_b = 8'd0;
        bi_a.byte_valid = 1'b0; bi_a.byte_data = 8'h00;
        bi_b.byte_valid = 1'b0; bi_b.byte_data = 8'h00;

        #3;
        check_idle("rst_a", 0);
        check_idle("rst_b", 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // One byte 0xB4, byte_valid held high throughout
        build(4, 8, 1, 8'hB4, 8'h00, -1, 0, 1'b0);
        apply("b4", 0, q.size());

        // Two bytes back-to-back, stray start pulses mid-frame
        build(4, 8, 2, 8'hFF, 8'h00, -1, 0, 1'b1);
        apply("ff00", 0, q.size());

        // Second byte withheld 5 cycles past its boundary
        build(4, 8, 2, 8'hA5, 8'h3C, 1, 5, 1'b0);
        apply("stall", 0, q.size());

        // Zero-length start is ignored
        q.delete();
        v = '{default: 0};
        v.start = 1'b1; v.flen = 8'd0; v.vin = 1'b1; v.data = 8'h55;
        q.push_back(v);
        v.start = 1'b0;
        for (int i = 0; i < 5; i++) q.push_back(v);
        apply("zlen", 0, q.size());

        // SPS=1, PRE_LEN=2, byte 0x1B
        build(1, 2, 1, 8'h1B, 8'h00, -1, 0, 1'b0);
        apply("sps1", 1, q.size());

        // Async reset mid-payload drops the frame with no done pulse
        build(4, 8, 1, 8'hB4, 8'h00, -1, 0, 1'b0);
        apply("prerst", 0, 40);
        check("prerst.sv", 8'(a_sv), 8'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("arst", 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_idle($sformatf("postrst%0d", i), 0);
        end

        // Fresh frame after reset behaves normally
        build(4, 8, 1, 8'hB4, 8'h00, -1, 0, 1'b0);
        apply("again", 0, q.size());

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
